instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Fetch stage directly upstream of the single-cycle core. Issues word reads to instruction memory over a valid/ready request channel with an in-order response channel. Buffers returned words with their PCs in a small prefetch FIFO and presents one instruction per cycle to the core. Honours branch/jump redirects by flushing the FIFO and discarding stale in-flight responses.

Parameters:
XLEN, 32, address/instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 4, prefetch entries (power of two, >= 2); also bounds requests in flight

Ports:
clk  in  1  clock
srst  in  1  synchronous active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  word-aligned fetch address
imem_rsp_valid  in  1  one in-order response this cycle (always accepted)
imem_rsp_data  in  XLEN  instruction word
imem_rsp_err  in  1  access fault for this response
redirect_valid  in  1  branch/jump taken; flush and restart
redirect_pc  in  XLEN  new fetch target
instr_valid  out  1  instr/instr_pc/instr_fault valid
instr_ready  in  1  core consumes instruction
instr  out  XLEN  instruction to core
instr_pc  out  XLEN  PC of instr
instr_fault  out  1  fetch fault flag for instr

Behaviour:
- Interface: one clock clk; reset srst is synchronous and active-high.
- Reset: fetch_pc=rsp_pc=RESET_PC, FIFO empty, inflight=0, drop=0. Outputs: imem_req_valid=0, instr_valid=0, instr=NOP_INSTR (32'h0000_0013), instr_pc=0, instr_fault=0. instr=NOP_INSTR whenever the FIFO is empty.
- Counters: inflight = issued minus responded; drop (<= inflight) = responses still to discard. Width $clog2(FIFO_DEPTH+1).
- Credit: imem_req_valid = !srst && !redirect_valid && (count + inflight - drop) < FIFO_DEPTH. The FIFO therefore never overflows.
- imem_req_addr = fetch_pc. Held stable while valid && !ready. On handshake: fetch_pc += 4, inflight++.
- Response: inflight--. If drop>0 or redirect_valid the same cycle, discard it; when drop>0, drop--. Otherwise push {imem_rsp_err, rsp_pc, imem_rsp_data} and advance rsp_pc by 4.
- Response with inflight==0 is a protocol violation: ignore it and flag an assertion.
- Output: instr_valid = !empty && !redirect_valid. Pop on instr_valid && instr_ready.
- Latency: a response in cycle N becomes visible in cycle N+1 (registered FIFO, no bypass). A simultaneous push and pop leaves count unchanged.
- Redirect (highest priority): in that cycle the FIFO is cleared and any pop is ignored.
  - fetch_pc = rsp_pc = {redirect_pc[XLEN-1:2],2'b00}.
  - drop_next = inflight - rsp_valid. No request is issued that cycle.
  - Fetching resumes the next cycle.
- Faults do not stop fetch. The faulting word is delivered with instr_fault=1; the core decides on the trap.
- Reset mid-operation: all state returns to reset values next edge. Responses arriving after reset, for pre-reset requests, are the memory's responsibility; the memory must also reset on srst.
- PC wrap 32'hFFFF_FFFC+4 -> 0, with no special handling.

Decomposition:
- Shared package risc_pkg: XLEN, NOP_INSTR, typedef struct packed {logic fault; logic [XLEN-1:0] pc; logic [XLEN-1:0] instr;} fetch_entry_t.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush, count, empty, full; flush overrides push/pop.
- Credit, drop and PC logic live in instr_fetch_unit.

Test Plan:
- Reset release; req_ready=1; memory returns data=addr^32'hA5A5_0000 after 1 cycle; instr_ready=1 -> request addresses 0,4,8,...; instr_pc=0 valid 2 cycles after first handshake; one instr per cycle thereafter in order.
- instr_ready=0, FIFO_DEPTH=4 -> exactly 4 request handshakes, then imem_req_valid=0; pulse instr_ready one cycle -> exactly one further request (addr 0x10).
- imem_req_ready=0 for 3 cycles with addr 0x8 pending -> imem_req_addr holds 0x8; issues 0x8 then 0xC after ready rises.
- 2 requests in flight (0x10,0x14), redirect_pc=0x100 -> both responses dropped, no instr_valid for them, FIFO flushed; next instr_pc=0x100.
- Redirect coincident with a response, redirect_pc=0x102 -> that response discarded, fetch restarts at 0x100, drop equals remaining inflight.
- Response with imem_rsp_err=1 at 0x20 -> instr_fault=1, instr_pc=0x20; following instr 0x24 has instr_fault=0.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the fetch path.
//   XLEN          : address / instruction width
//   NOP_INSTR     : instruction presented to the core when nothing is buffered
//   fetch_entry_t : one prefetch FIFO entry {fault, pc, instr}
package risc_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic            fault;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch_entry_t.
//   clk, srst   : clock, synchronous active-high reset
//   push, wdata : write an entry (ignored when full)
//   pop         : discard the head entry (ignored when empty)
//   flush       : empty the FIFO; overrides push and pop
//   rdata       : head entry (undefined when empty)
//   count       : number of stored entries
//   empty, full : status flags
module fetch_fifo
    import risc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry_t                 wdata,
    output fetch_entry_t                 rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push_eff;
    logic            pop_eff;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign push_eff = push && !full && !flush;
    assign pop_eff  = pop && !empty && !flush;
    assign rdata    = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_eff, pop_eff})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues word reads to instruction memory, buffers
// responses with their PCs and hands one instruction per cycle to the core.
// A redirect flushes the buffer and discards responses still in flight.
//   clk, srst          : clock, synchronous active-high reset
//   imem_req_*         : request channel (valid/ready, word-aligned address)
//   imem_rsp_*         : in-order response channel, always accepted
//   redirect_valid/pc  : taken branch/jump, restart fetch at redirect_pc
//   instr_valid/ready  : handshake towards the core
//   instr, instr_pc    : instruction word and its PC (NOP / 0 when empty)
//   instr_fault        : access fault reported for instr
module instr_fetch_unit
    import risc_pkg::*;
#(
    parameter int                        XLEN       = risc_pkg::XLEN,
    parameter logic [risc_pkg::XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                        FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            srst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_fault
);

    localparam int CW = $clog2(FIFO_DEPTH+1);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   count;
    logic [CW:0]     credit_used;
    logic [XLEN-1:0] target_pc;
    logic            req_fire;
    logic            rsp_ok;
    logic            rsp_keep;
    logic            fifo_empty;
    logic            fifo_pop;
    logic            unused_full;
    logic            unused_bits;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // Entries buffered plus responses that will still be pushed; requests
    // are issued only while that total leaves room in the FIFO.
    assign credit_used = {1'b0, count} + {1'b0, inflight} - {1'b0, drop};

    assign imem_req_valid = !srst && !redirect_valid &&
                            (credit_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is ignored entirely.
    assign rsp_ok   = imem_rsp_valid && (inflight != '0);
    assign rsp_keep = rsp_ok && (drop == '0) && !redirect_valid;

    assign target_pc   = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_bits = ^redirect_pc[1:0];

    assign push_entry = '{fault: imem_rsp_err, pc: rsp_pc, instr: imem_rsp_data};

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .srst  (srst),
        .push  (rsp_keep),
        .pop   (fifo_pop),
        .flush (redirect_valid),
        .wdata (push_entry),
        .rdata (head),
        .count (count),
        .empty (fifo_empty),
        .full  (unused_full)
    );

    assign instr_valid = !fifo_empty && !redirect_valid;
    assign fifo_pop    = instr_valid && instr_ready;
    assign instr       = fifo_empty ? NOP_INSTR : head.instr;
    assign instr_pc    = fifo_empty ? '0 : head.pc;
    assign instr_fault = !fifo_empty && head.fault;

    always_ff @(posedge clk) begin
        if (srst) begin
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            drop     <= '0;
        end else begin
            // No request fires during a redirect, so only the response term
            // moves inflight in that cycle.
            inflight <= inflight + CW'(req_fire) - CW'(rsp_ok);
            if (redirect_valid) begin
                fetch_pc <= target_pc;
                rsp_pc   <= target_pc;
                drop     <= inflight - CW'(rsp_ok);
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (rsp_keep) begin
                    rsp_pc <= rsp_pc + XLEN'(4);
                end
                if (rsp_ok && (drop != '0)) begin
                    drop <= drop - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!srst) begin
            assert (!(imem_rsp_valid && (inflight == '0)));
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk;
    logic        srst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_fault;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    // memory model state
    int          lat      = 1;
    logic [31:0] err_addr = 32'h0000_0001;
    int          cyc      = 0;
    int          hs_count = 0;
    logic [31:0] q_addr [$];
    int          q_due  [$];
    logic [31:0] mem_a;

    instr_fetch_unit dut (
        .clk            (clk),
        .srst           (srst),
        .imem_req_valid (req_valid),
        .imem_req_ready (req_ready),
        .imem_req_addr  (req_addr),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data),
        .imem_rsp_err   (rsp_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_fault    (instr_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // In-order memory: a request accepted at an edge answers lat edges later.
    initial begin
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (srst) begin
                q_addr.delete();
                q_due.delete();
            end else if (req_valid && req_ready) begin
                q_addr.push_back(req_addr);
                q_due.push_back(cyc + lat);
                hs_count++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (q_addr.size() > 0 && q_due[0] <= cyc) begin
                mem_a = q_addr.pop_front();
                void'(q_due.pop_front());
                rsp_valid = 1'b1;
                rsp_data  = mem_a ^ 32'hA5A5_0000;
                rsp_err   = (mem_a == err_addr);
            end else begin
                rsp_valid = 1'b0;
                rsp_data  = '0;
                rsp_err   = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        srst = 1'b1;
        step();
        step();
        srst = 1'b0;
        #1;
    endtask

    int base;

    initial begin
        srst           = 1'b1;
        req_ready      = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // reset state
        step();
        step();
        #1;
        chk("rst_req_valid",   32'(req_valid),   32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr_nop",   instr,            32'h0000_0013);
        chk("rst_instr_pc",    instr_pc,         32'd0);
        chk("rst_instr_fault", 32'(instr_fault), 32'd0);

        // streaming: one instruction per cycle in order
        do_reset();
        chk("s1_first_addr", req_addr, 32'h0);
        chk("s1_first_valid", 32'(req_valid), 32'd1);
        step();
        #1;
        chk("s1_addr_e1", req_addr, 32'h4);
        chk("s1_ivalid_e1", 32'(instr_valid), 32'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            #1;
            chk("s1_ivalid", 32'(instr_valid), 32'd1);
            chk("s1_pc",     instr_pc,         32'(4 * k));
            chk("s1_instr",  instr,            32'(4 * k) ^ 32'hA5A5_0000);
            chk("s1_fault",  32'(instr_fault), 32'd0);
        end

        // back-pressure: FIFO fills after exactly four requests
        instr_ready = 1'b0;
        do_reset();
        base = hs_count;
        repeat (8) step();
        #1;
        chk("s2_hs_full",   32'(hs_count - base), 32'd4);
        chk("s2_req_idle",  32'(req_valid),       32'd0);
        chk("s2_ivalid",    32'(instr_valid),     32'd1);
        chk("s2_head_pc",   instr_pc,             32'h0);
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        #1;
        chk("s2_req_again", 32'(req_valid), 32'd1);
        chk("s2_req_addr",  req_addr,       32'h10);
        repeat (3) step();
        #1;
        chk("s2_hs_one_more", 32'(hs_count - base), 32'd5);
        chk("s2_req_idle2",   32'(req_valid),       32'd0);
        chk("s2_head_pc2",    instr_pc,             32'h4);
        chk("s2_fetch_pc",    req_addr,             32'h14);

        // request stall holds the address
        instr_ready = 1'b1;
        do_reset();
        step();
        step();
        #1;
        chk("s3_addr_pre", req_addr, 32'h8);
        req_ready = 1'b0;
        base = hs_count;
        for (int k = 0; k < 3; k++) begin
            step();
            #1;
            chk("s3_hold_addr",  req_addr,       32'h8);
            chk("s3_hold_valid", 32'(req_valid), 32'd1);
        end
        chk("s3_no_hs", 32'(hs_count - base), 32'd0);
        req_ready = 1'b1;
        step();
        #1;
        chk("s3_after_8", req_addr, 32'hC);
        step();
        #1;
        chk("s3_after_c", req_addr, 32'h10);

        // redirect with two requests in flight (0x10, 0x14)
        lat = 2;
        do_reset();
        repeat (6) step();
        #1;
        chk("s4_addr",    req_addr, 32'h18);
        chk("s4_head_pc", instr_pc, 32'hC);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        chk("s4_redir_ivalid", 32'(instr_valid), 32'd0);
        chk("s4_redir_req",    32'(req_valid),   32'd0);
        chk("s4_redir_rsp",    32'(rsp_valid),   32'd1);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("s4_flushed",   32'(instr_valid), 32'd0);
        chk("s4_flush_nop", instr,            32'h0000_0013);
        chk("s4_new_addr",  req_addr,         32'h100);
        chk("s4_new_valid", 32'(req_valid),   32'd1);
        step();
        #1;
        chk("s4_stale_dropped", 32'(instr_valid), 32'd0);
        step();
        #1;
        chk("s4_wait", 32'(instr_valid), 32'd0);
        step();
        #1;
        chk("s4_new_ivalid", 32'(instr_valid), 32'd1);
        chk("s4_new_pc",     instr_pc,         32'h100);
        chk("s4_new_instr",  instr,            32'hA5A5_0100);

        // redirect coincident with a response, misaligned target
        lat = 1;
        do_reset();
        repeat (4) step();
        #1;
        chk("s5_head_pc", instr_pc, 32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        #1;
        chk("s5_redir_rsp", 32'(rsp_valid), 32'd1);
        step();
        redirect_valid = 1'b0;
        #1;
        chk("s5_addr_aligned", req_addr,         32'h100);
        chk("s5_ivalid0",      32'(instr_valid), 32'd0);
        step();
        #1;
        chk("s5_ivalid1", 32'(instr_valid), 32'd0);
        step();
        #1;
        chk("s5_ivalid",  32'(instr_valid), 32'd1);
        chk("s5_pc",      instr_pc,         32'h100);
        step();
        #1;
        chk("s5_pc_next", instr_pc, 32'h104);

        // fault at 0x20, then PC wrap after a redirect to the top of memory
        err_addr = 32'h20;
        do_reset();
        repeat (10) step();
        #1;
        chk("s6_fault_pc",    instr_pc,         32'h20);
        chk("s6_fault",       32'(instr_fault), 32'd1);
        chk("s6_fault_valid", 32'(instr_valid), 32'd1);
        chk("s6_fault_instr", instr,            32'hA5A5_0020);
        step();
        #1;
        chk("s6_next_pc",    instr_pc,         32'h24);
        chk("s6_next_fault", 32'(instr_fault), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        step();
        redirect_valid = 1'b0;
        #1;
        chk("s7_addr_top", req_addr, 32'hFFFF_FFFC);
        step();
        #1;
        chk("s7_addr_wrap", req_addr, 32'h0);
        step();
        #1;
        chk("s7_pc_top",    instr_pc, 32'hFFFF_FFFC);
        chk("s7_instr_top", instr,    32'h5A5A_FFFC);
        step();
        #1;
        chk("s7_pc_wrap",    instr_pc, 32'h0);
        chk("s7_instr_wrap", instr,    32'hA5A5_0000);

        // reset mid-stream clears buffered state
        srst = 1'b1;
        step();
        #1;
        chk("s8_rst_ivalid", 32'(instr_valid), 32'd0);
        chk("s8_rst_req",    32'(req_valid),   32'd0);
        chk("s8_rst_nop",    instr,            32'h0000_0013);
        srst = 1'b0;
        #1;
        chk("s8_rst_addr", req_addr, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
